digit_scan: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display on the adder board. It generates the 2-bit digit select `sel` that drives the existing 4:1 nibble multiplexor's `btn` input, plus the registered active-low anode enables and decimal point. Each digit slot starts with a programmable blanking interval, so the multiplexor and the downstream segment decoder settle before the anode turns on (no ghosting).

---
 rtl/digit_scan_pkg.sv | 35 +++
 rtl/digit_scan_if.sv | 30 +++
 rtl/digit_scan_slot_counter.sv | 54 +++++
 rtl/digit_scan.sv | 83 ++++++++
 tb/tb_digit_scan.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/digit_scan_pkg.sv
// ============================================================================
// digit_scan_pkg : display constants and helpers shared by the scan logic
// Revision       : 1.0
// ============================================================================
`default_nettype none

package digit_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [SEL_W-1:0]      sel_t;
    typedef logic [NUM_DIGITS-1:0] digit_vec_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_LIT   = 1'b1
    } phase_e;

    // A counter must hold values 0..prescale-1 and be at least one bit wide.
    function automatic int cnt_width(input int prescale);
        return (prescale > 2) ? $clog2(prescale) : 1;
    endfunction

    function automatic digit_vec_t an_one_cold(input sel_t s);
        digit_vec_t v;
        v    = AN_OFF;
        v[s] = 1'b0;
        return v;
    endfunction

endpackage : digit_scan_pkg

`default_nettype wire

// File: rtl/digit_scan_if.sv
// ============================================================================
// digit_scan_if : control inputs and display drive outputs of the scan block
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface digit_scan_if;
    import digit_scan_pkg::*;

    logic       en;
    digit_vec_t digit_en;
    digit_vec_t dp_in;
    sel_t       sel;
    digit_vec_t an;
    logic       dp;
    logic       frame_tick;

    modport master (
        output en, digit_en, dp_in,
        input  sel, an, dp, frame_tick
    );

    modport slave (
        input  en, digit_en, dp_in,
        output sel, an, dp, frame_tick
    );

endinterface : digit_scan_if

`default_nettype wire

// File: rtl/digit_scan_slot_counter.sv
// ============================================================================
// slot_counter : free-running 0..PRESCALE-1 slot counter with hold and wrap
// Revision     : 1.0
// ============================================================================
`default_nettype none

module slot_counter
    import digit_scan_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = cnt_width(PRESCALE)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             hold_i,
    output logic [CNT_W-1:0]      cnt_o,
    output logic [CNT_W-1:0]      cnt_d_o,
    output logic                  wrap_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    always_comb begin
        wrap  = 1'b0;
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (cnt_q == CNT_MAX) begin
                wrap  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
    assign wrap_o  = wrap;

endmodule : slot_counter

`default_nettype wire

// File: rtl/digit_scan.sv
// ============================================================================
// digit_scan : 4-digit seven-segment scan controller with per-slot blanking
// Revision   : 1.0
// ============================================================================
`default_nettype none

module digit_scan
    import digit_scan_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 500
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    digit_scan_if.slave      bus
);

    localparam int               CNT_W   = cnt_width(PRESCALE);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    sel_t       sel_q,  sel_d;
    digit_vec_t an_q,   an_d;
    logic       dp_q,   dp_d;
    logic       tick_q, tick_d;
    phase_e     phase;

    slot_counter #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (~bus.en),
        .cnt_o   (cnt_q),
        .cnt_d_o (cnt_d),
        .wrap_o  (wrap)
    );

    // Outputs are decoded from the next counter/select so that all of them
    // land on the same edge and stay coherent with sel.
    always_comb begin
        sel_d  = wrap ? sel_t'(sel_q + sel_t'(1)) : sel_q;
        phase  = (cnt_d < BLANK_C) ? PH_BLANK : PH_LIT;
        an_d   = AN_OFF;
        dp_d   = 1'b1;
        tick_d = 1'b0;
        if (bus.en) begin
            tick_d = wrap && (sel_q == sel_t'(NUM_DIGITS - 1));
            if (phase == PH_LIT) begin
                if (bus.digit_en[sel_d]) begin
                    an_d = an_one_cold(sel_d);
                end
                dp_d = ~(bus.dp_in[sel_d] & bus.digit_en[sel_d]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            an_q   <= AN_OFF;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
            tick_q <= tick_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule : digit_scan

`default_nettype wire

// File: tb/tb_digit_scan.sv
// ============================================================================
// tb_digit_scan : scoreboard bench for digit_scan with PRESCALE=4, BLANK=1
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_digit_scan;

    logic clk;
    logic rst_n;

    digit_scan_if bus ();

    digit_scan #(
        .PRESCALE (4),
        .BLANK    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [1:0] sel;
        logic [3:0] an;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_id   = 0;
    event chk_ev;

    task automatic push(input logic [1:0] s, input logic [3:0] a,
                        input logic d, input logic f);
        exp_t e;
        e.id = cyc_id; e.sel = s; e.an = a; e.dp = d; e.ft = f;
        q.push_back(e);
    endtask

    // One clock: record what the DUT must show after this edge, then move
    // off the edge so later input changes are cleanly sampled next edge.
    task automatic cyc(input logic [1:0] s, input logic [3:0] a,
                       input logic d, input logic f);
        @(posedge clk);
        cyc_id++;
        push(s, a, d, f);
        #1;
    endtask

    task automatic slot(input logic [1:0] s, input logic [3:0] lit_an,
                        input logic lit_dp);
        cyc(s, 4'b1111, 1'b1, 1'b0);
        repeat (3) cyc(s, lit_an, lit_dp, 1'b0);
    endtask

    // Monitor: compares at every falling edge, or on demand for async events.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (bus.sel === e.sel && bus.an === e.an &&
                    bus.dp === e.dp && bus.frame_tick === e.ft) begin
                    n_pass++;
                end else begin
                    $display("FAIL cyc%0d sel/an/dp/ft got %b/%b/%b/%b want %b/%b/%b/%b",
                             e.id, bus.sel, bus.an, bus.dp, bus.frame_tick,
                             e.sel, e.an, e.dp, e.ft);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.digit_en = 4'b1111;
        bus.dp_in    = 4'b0000;

        // Reset state, held across edges
        cyc(2'd0, 4'b1111, 1'b1, 1'b0);
        cyc(2'd0, 4'b1111, 1'b1, 1'b0);
        rst_n  = 1'b1;
        cyc_id = 0;

        // Frame 1: full scan
        repeat (3) cyc(2'd0, 4'b1110, 1'b1, 1'b0);
        slot(2'd1, 4'b1101, 1'b1);
        slot(2'd2, 4'b1011, 1'b1);
        slot(2'd3, 4'b0111, 1'b1);
        cyc(2'd0, 4'b1111, 1'b1, 1'b1);

        // Frame 2: digits 1 and 3 masked
        bus.digit_en = 4'b0101;
        repeat (3) cyc(2'd0, 4'b1110, 1'b1, 1'b0);
        slot(2'd1, 4'b1111, 1'b1);
        slot(2'd2, 4'b1011, 1'b1);
        slot(2'd3, 4'b1111, 1'b1);
        cyc(2'd0, 4'b1111, 1'b1, 1'b1);

        // Frame 3: decimal point on digit 1
        bus.digit_en = 4'b1111;
        bus.dp_in    = 4'b0010;
        repeat (3) cyc(2'd0, 4'b1110, 1'b1, 1'b0);
        slot(2'd1, 4'b1101, 1'b0);
        slot(2'd2, 4'b1011, 1'b1);
        slot(2'd3, 4'b0111, 1'b1);
        cyc(2'd0, 4'b1111, 1'b1, 1'b1);

        // Frame 4: enable hold mid-slot in digit 1
        repeat (3) cyc(2'd0, 4'b1110, 1'b1, 1'b0);
        cyc(2'd1, 4'b1111, 1'b1, 1'b0);
        cyc(2'd1, 4'b1101, 1'b0, 1'b0);
        bus.en = 1'b0;
        repeat (10) cyc(2'd1, 4'b1111, 1'b1, 1'b0);
        bus.en = 1'b1;
        repeat (2) cyc(2'd1, 4'b1101, 1'b0, 1'b0);
        cyc(2'd2, 4'b1111, 1'b1, 1'b0);
        repeat (2) cyc(2'd2, 4'b1011, 1'b1, 1'b0);

        // Asynchronous reset between edges while digit 2 is lit
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 push(2'd0, 4'b1111, 1'b1, 1'b0);
        -> chk_ev;
        cyc(2'd0, 4'b1111, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) cyc(2'd0, 4'b1110, 1'b1, 1'b0);
        cyc(2'd1, 4'b1111, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: pending entries got %0d want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_digit_scan

`default_nettype wire
